// File: rtl/scan_chain_ctrl_pkg.sv
// Shared definitions for the scan chain controller slice.
// Contents:
//   DEF_CHAIN_LEN - default number of scan cells in the chain
//   state_t       - controller FSM states
package scan_ctrl_pkg;

   localparam int DEF_CHAIN_LEN = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT_IN  = 3'd1,
      CAPTURE   = 3'd2,
      SHIFT_OUT = 3'd3,
      DONE      = 3'd4
   } state_t;

endpackage

// File: rtl/scan_chain_ctrl_if.sv
// Host and chain signals of the scan chain controller.
// Signals:
//   start, pattern_in          - host request and stimulus
//   response, busy, done       - host result and status
//   scan_en, scan_in, scan_out - chain mux select, serial in, serial out
// Modports:
//   slave  - the controller
//   master - the host/chain environment
interface scan_chain_ctrl_if
   import scan_ctrl_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN
);

   logic                 start;
   logic [CHAIN_LEN-1:0] pattern_in;
   logic                 scan_en;
   logic                 scan_in;
   logic                 scan_out;
   logic [CHAIN_LEN-1:0] response;
   logic                 busy;
   logic                 done;

   modport slave (
      input  start, pattern_in, scan_out,
      output scan_en, scan_in, response, busy, done
   );

   modport master (
      output start, pattern_in, scan_out,
      input  scan_en, scan_in, response, busy, done
   );

endinterface

// File: rtl/scan_chain_ctrl_bit_counter.sv
// Loadable down-counter timing both shift phases of the controller.
// Ports:
//   clk, rst - clock and synchronous active-high reset (clears to 0)
//   load     - reload with LOAD_VAL (has priority over dec)
//   dec      - decrement by one
//   last     - count is 1, i.e. the current cycle is the final one of a phase
module scan_bit_counter #(
   parameter int WIDTH    = 4,
   parameter int LOAD_VAL = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic last
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= WIDTH'(LOAD_VAL);
      end else if (dec) begin
         count <= count - 1'b1;
      end
   end

   // The phase ends on a count of 1 and the counter reloads there,
   // so it never wraps through zero.
   assign last = (count == WIDTH'(1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequencer for a single mux-based scan chain. On an accepted start it
// shifts the pattern in (MSB first), pulses one capture cycle, shifts the
// captured state out and presents it in parallel on response with a
// one-cycle done pulse.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   bus      - scan_chain_ctrl_if.slave: start/pattern_in/response/busy/done
//              towards the host, scan_en/scan_in/scan_out towards the chain
module scan_chain_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter  int CHAIN_LEN = DEF_CHAIN_LEN,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   scan_chain_ctrl_if.slave  bus
);

   state_t               state;
   logic [CHAIN_LEN-1:0] sreg;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_last;

   // Appends the sampled scan_out bit at the LSB; the first sample ends up
   // in the MSB after CHAIN_LEN shifts, matching cell N-1 coming out first.
   function automatic logic [CHAIN_LEN-1:0] shift_in_bit(
      input logic [CHAIN_LEN-1:0] v,
      input logic                 b
   );
      logic [CHAIN_LEN:0] tmp;
      tmp = {v, b};
      return tmp[CHAIN_LEN-1:0];
   endfunction

   always_comb begin
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state)
         IDLE:                cnt_load = bus.start;
         SHIFT_IN, SHIFT_OUT: begin
            cnt_dec  = 1'b1;
            cnt_load = cnt_last;
         end
         default: ;
      endcase
   end

   scan_bit_counter #(
      .WIDTH    (CNT_W),
      .LOAD_VAL (CHAIN_LEN)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .dec  (cnt_dec),
      .last (cnt_last)
   );

   // sreg holds the remaining pattern bits during SHIFT_IN. It has shifted
   // down to all zeros by the end of that phase and is then reused to
   // gather the scan_out samples during SHIFT_OUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sreg         <= '0;
         bus.scan_en  <= 1'b0;
         bus.scan_in  <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.response <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state       <= SHIFT_IN;
                  sreg        <= bus.pattern_in << 1;
                  bus.scan_in <= bus.pattern_in[CHAIN_LEN-1];
                  bus.scan_en <= 1'b1;
                  bus.busy    <= 1'b1;
               end
            end
            SHIFT_IN: begin
               if (cnt_last) begin
                  state       <= CAPTURE;
                  bus.scan_en <= 1'b0;
                  bus.scan_in <= 1'b0;
               end else begin
                  bus.scan_in <= sreg[CHAIN_LEN-1];
                  sreg        <= sreg << 1;
               end
            end
            CAPTURE: begin
               state       <= SHIFT_OUT;
               bus.scan_en <= 1'b1;
            end
            SHIFT_OUT: begin
               sreg <= shift_in_bit(sreg, bus.scan_out);
               if (cnt_last) begin
                  state        <= DONE;
                  bus.scan_en  <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.response <= shift_in_bit(sreg, bus.scan_out);
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
